// File: rtl/bw_r_frf_gen_pkg.sv
// bw_r_frf_gen_pkg: shared constants and FSM encoding for the FRF.
// Holds default geometry plus an address-width helper.
package bw_r_frf_gen_pkg;

  localparam int DEF_LANES  = 2;
  localparam int DEF_LANE_W = 39;
  localparam int DEF_DEPTH  = 128;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  function automatic int addr_w(int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/bw_r_frf_gen_if.sv
// bw_r_frf_gen_if: user write/read port bundle of the FRF.
// master drives requests; slave returns rd_data and init_busy.
interface bw_r_frf_gen_if
  import bw_r_frf_gen_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W,
  parameter int DEPTH  = DEF_DEPTH
) ();

  localparam int AW = addr_w(DEPTH);
  localparam int DW = LANES * LANE_W;

  logic [LANES-1:0] wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [DW-1:0]    rd_data;
  logic             init_busy;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_en, rd_addr,
    input  rd_data, init_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_en, rd_addr,
    output rd_data, init_busy
  );

endinterface

// File: rtl/bw_r_frf_gen_array.sv
// bw_r_frf_gen_array: LANES x LANE_W x DEPTH storage, no reset.
// Ports: clk, per-lane we, waddr/wdata, raddr, combinational rdata.
module bw_r_frf_gen_array
  import bw_r_frf_gen_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int AW    = addr_w(DEPTH),
  localparam int DW    = LANES * LANE_W
) (
  input  logic             clk,
  input  logic [LANES-1:0] we,
  input  logic [AW-1:0]    waddr,
  input  logic [DW-1:0]    wdata,
  input  logic [AW-1:0]    raddr,
  output logic [DW-1:0]    rdata
);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [LANE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we[k]) begin
        mem[waddr] <= wdata[k*LANE_W +: LANE_W];
      end
    end

    assign rdata[k*LANE_W +: LANE_W] = mem[raddr];
  end

endmodule

// File: rtl/bw_r_frf_gen.sv
// bw_r_frf_gen: 2-stage register file with per-lane writes and clear FSM.
// Ports: rclk, rst_l, sehold, clr_req, bus (slave: wr/rd req, rd_data, init_busy).
module bw_r_frf_gen
  import bw_r_frf_gen_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic           rclk,
  input  logic           rst_l,
  input  logic           sehold,
  input  logic           clr_req,
  bw_r_frf_gen_if.slave  bus
);

  localparam int AW = addr_w(DEPTH);
  localparam int DW = LANES * LANE_W;
  localparam logic [AW:0]   LIMIT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  state_t           state;
  logic [AW-1:0]    cnt;
  logic             busy;

  logic [LANES-1:0] s1_we;
  logic [AW-1:0]    s1_waddr;
  logic [DW-1:0]    s1_wdata;
  logic             s1_re;
  logic [AW-1:0]    s1_raddr;

  logic             w_ok;
  logic             rd_ok;
  logic             same;
  logic [LANES-1:0] usr_we;
  logic [LANES-1:0] arr_we;
  logic [AW-1:0]    arr_waddr;
  logic [DW-1:0]    arr_wdata;
  logic [DW-1:0]    arr_rdata;
  logic [DW-1:0]    rd_next;
  logic [DW-1:0]    rd_q;

  assign busy   = (state == CLEAR);
  assign w_ok   = ({1'b0, s1_waddr} < LIMIT);
  assign rd_ok  = s1_re && !busy
                  && ({1'b0, s1_raddr} < LIMIT);
  assign same   = (s1_waddr == s1_raddr);
  assign usr_we = (busy || !w_ok) ? '0 : s1_we;

  // The clear sequence owns the write port while busy.
  assign arr_we    = sehold ? '0
                   : busy   ? '1 : usr_we;
  assign arr_waddr = busy ? cnt : s1_waddr;
  assign arr_wdata = busy ? '0  : s1_wdata;

  bw_r_frf_gen_array #(
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (rclk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (s1_raddr),
    .rdata (arr_rdata)
  );

  // Write-first bypass per lane on a same-entry collision.
  for (genvar k = 0; k < LANES; k++) begin : g_byp
    assign rd_next[k*LANE_W +: LANE_W] =
      !rd_ok ? '0
      : (usr_we[k] && same) ? s1_wdata[k*LANE_W +: LANE_W]
      : arr_rdata[k*LANE_W +: LANE_W];
  end

  // Requests presented while busy never enter the pipe.
  always_ff @(posedge rclk or negedge rst_l) begin
    if (!rst_l) begin
      s1_we    <= '0;
      s1_waddr <= '0;
      s1_wdata <= '0;
      s1_re    <= 1'b0;
      s1_raddr <= '0;
    end else if (!sehold) begin
      s1_we    <= busy ? '0 : bus.wr_en;
      s1_waddr <= bus.wr_addr;
      s1_wdata <= bus.wr_data;
      s1_re    <= busy ? 1'b0 : bus.rd_en;
      s1_raddr <= bus.rd_addr;
    end
  end

  always_ff @(posedge rclk or negedge rst_l) begin
    if (!rst_l) begin
      state <= CLEAR;
      cnt   <= '0;
    end else if (!sehold) begin
      unique case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge rclk or negedge rst_l) begin
    if (!rst_l) begin
      rd_q <= '0;
    end else if (!sehold) begin
      rd_q <= rd_next;
    end
  end

  assign bus.rd_data   = rd_q;
  assign bus.init_busy = busy;

endmodule

// File: tb/tb_bw_r_frf_gen.sv
// tb_bw_r_frf_gen: vector table + scoreboard bench for bw_r_frf_gen.
// Drives the interface master side; checks rd_data and init_busy.
module tb_bw_r_frf_gen;
  import bw_r_frf_gen_pkg::*;

  localparam logic [77:0]  A  = 78'h3FFF_0000_1234_5678_9ABC;
  localparam logic [38:0]  O  = 39'h7F_FFFF_FFFF;
  localparam logic [38:0]  Z  = 39'h0;
  localparam logic [77:0]  B  = {39'h12_3456_789A, 39'h05_4321_0FED};
  localparam logic [77:0]  C  = {39'h00_ABCD_EF01, 39'h11_2233_4455};
  localparam logic [77:0]  L5 = {39'h1234, 39'h55};
  localparam logic [77:0]  X5 = {39'h1234, 39'h0};

  logic rclk = 1'b0;
  logic rst_l = 1'b0;
  logic sehold = 1'b0;
  logic clr_req = 1'b0;

  bw_r_frf_gen_if #(
    .LANES(2), .LANE_W(39), .DEPTH(128)
  ) bus ();

  bw_r_frf_gen #(
    .LANES(2), .LANE_W(39), .DEPTH(128)
  ) dut (
    .rclk    (rclk),
    .rst_l   (rst_l),
    .sehold  (sehold),
    .clr_req (clr_req),
    .bus     (bus)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic [77:0] exp;
    int          id;
  } sb_t;
  sb_t q[$];

  typedef struct {
    logic [1:0]  we;
    logic [6:0]  waddr;
    logic [77:0] wdata;
    logic        re;
    logic [6:0]  raddr;
    logic [77:0] exp;
  } vec_t;
  vec_t vt [14];

  always @(posedge rclk) cyc++;

  task automatic chk(string name, logic [77:0] act,
                     logic [77:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  always @(negedge rclk) begin
    sb_t e;
    while (q.size() > 0 && q[0].due < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL sb%0d: result not sampled", e.id);
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk($sformatf("sb%0d", e.id), bus.rd_data, e.exp);
    end
  end

  function automatic vec_t mk(logic [1:0] we,
      logic [6:0] wa, logic [77:0] wd, logic re,
      logic [6:0] ra, logic [77:0] exp);
    vec_t v;
    v.we = we; v.waddr = wa; v.wdata = wd;
    v.re = re; v.raddr = ra; v.exp = exp;
    return v;
  endfunction

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic set_in(logic [1:0] we, logic [6:0] wa,
      logic [77:0] wd, logic re, logic [6:0] ra);
    bus.wr_en = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.rd_en = re;
    bus.rd_addr = ra;
  endtask

  task automatic idle_in();
    set_in(2'b00, 7'd0, 78'h0, 1'b0, 7'd0);
  endtask

  task automatic push(logic [77:0] exp, int id);
    sb_t e;
    e.due = cyc + 2;
    e.exp = exp;
    e.id = id;
    q.push_back(e);
  endtask

  task automatic rd(logic [6:0] a, logic [77:0] exp, int id);
    set_in(2'b00, 7'd0, 78'h0, 1'b1, a);
    push(exp, id);
    step();
  endtask

  task automatic drain();
    idle_in();
    for (int i = 0; i < 8 && q.size() > 0; i++) step();
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge rclk);
      if (!bus.init_busy) break;
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    vt[0]  = mk(2'b11, 7'd3,   A,        1'b0, 7'd0,   78'h0);
    vt[1]  = mk(2'b00, 7'd0,   78'h0,    1'b1, 7'd3,   A);
    vt[2]  = mk(2'b11, 7'd7,   {O, O},   1'b0, 7'd0,   78'h0);
    vt[3]  = mk(2'b01, 7'd7,   78'h0,    1'b1, 7'd7,   {O, Z});
    vt[4]  = mk(2'b00, 7'd0,   78'h0,    1'b1, 7'd7,   {O, Z});
    vt[5]  = mk(2'b10, 7'd7,   L5,       1'b1, 7'd7,   X5);
    vt[6]  = mk(2'b11, 7'd9,   B,        1'b1, 7'd3,   A);
    vt[7]  = mk(2'b00, 7'd0,   78'h0,    1'b1, 7'd9,   B);
    vt[8]  = mk(2'b00, 7'd0,   78'h0,    1'b1, 7'd0,   78'h0);
    vt[9]  = mk(2'b00, 7'd0,   78'h0,    1'b1, 7'd127, 78'h0);
    vt[10] = mk(2'b00, 7'd0,   78'h0,    1'b0, 7'd9,   78'h0);
    vt[11] = mk(2'b01, 7'd127, {Z, O},   1'b1, 7'd127, {Z, O});
    vt[12] = mk(2'b00, 7'd0,   78'h0,    1'b1, 7'd7,   X5);
    vt[13] = mk(2'b00, 7'd0,   78'h0,    1'b1, 7'd127, {Z, O});

    idle_in();
    repeat (3) @(posedge rclk);
    #1;
    chk("rst_rd_data", bus.rd_data, 78'h0);
    chk("rst_busy", 78'(bus.init_busy), 78'h1);

    rst_l = 1'b1;
    wait_clear(n);
    chk("init_len", 78'(n), 78'd128);
    step();
    rd(7'd5, 78'h0, 100);

    for (int i = 0; i < 14; i++) begin
      set_in(vt[i].we, vt[i].waddr, vt[i].wdata,
             vt[i].re, vt[i].raddr);
      push(vt[i].exp, i);
      step();
    end
    drain();

    set_in(2'b11, 7'd20, C, 1'b0, 7'd0);
    step();
    set_in(2'b00, 7'd0, 78'h0, 1'b1, 7'd3);
    step();
    set_in(2'b00, 7'd0, 78'h0, 1'b1, 7'd20);
    step();
    sehold = 1'b1;
    set_in(2'b11, 7'd20, {78{1'b1}}, 1'b1, 7'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold%0d", i), bus.rd_data, A);
    end
    sehold = 1'b0;
    idle_in();
    step();
    chk("hold_resume", bus.rd_data, C);
    step();
    chk("hold_idle", bus.rd_data, 78'h0);
    rd(7'd20, C, 200);
    rd(7'd3, A, 201);
    drain();

    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    chk("clr_busy", 78'(bus.init_busy), 78'h1);
    repeat (9) step();
    set_in(2'b11, 7'd3, A, 1'b0, 7'd0);
    step();
    idle_in();
    repeat (89) step();
    set_in(2'b00, 7'd0, 78'h0, 1'b1, 7'd127);
    step();
    idle_in();
    step();
    chk("clr_rd_zero", bus.rd_data, 78'h0);
    wait_clear(n);
    chk("clr_tail", 78'(n), 78'd27);
    step();
    rd(7'd3, 78'h0, 210);
    rd(7'd127, 78'h0, 211);
    rd(7'd7, 78'h0, 212);
    drain();

    set_in(2'b11, 7'd100, A, 1'b0, 7'd0);
    step();
    rd(7'd100, A, 220);
    drain();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (60) step();
    rst_l = 1'b0;
    #1;
    chk("rst60_busy", 78'(bus.init_busy), 78'h1);
    chk("rst60_rd", bus.rd_data, 78'h0);
    repeat (2) @(posedge rclk);
    #1;
    rst_l = 1'b1;
    wait_clear(n);
    chk("rst60_len", 78'(n), 78'd128);
    step();
    for (int a = 0; a < 128; a++) begin
      rd(7'(a), 78'h0, 300 + a);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/bw_r_frf_gen.md
BW_R_FRF_GEN -- requirements
Module: bw_r_frf_gen

Interface
REQ-001 Parameter LANES, default 2: independently write-enabled lanes per entry.
REQ-002 Parameter LANE_W, default 39: bits per lane (data plus ECC).
REQ-003 Parameter DEPTH, default 128: number of entries; AW = clog2(DEPTH).
REQ-004 rclk  in  1  only clock; all state updates on posedge rclk.
REQ-005 rst_l  in  1  reset, asynchronous and active-low.
REQ-006 sehold  in  1  freezes all pipeline and array state while high.
REQ-007 clr_req  in  1  pulse; requests a full-array clear.
REQ-008 wr_en  in  LANES  per-lane write enable.
REQ-009 wr_addr  in  AW  write entry index.
REQ-010 wr_data  in  LANES*LANE_W  write data; lane k occupies bits [k*LANE_W +: LANE_W].
REQ-011 rd_en  in  1  read request.
REQ-012 rd_addr  in  AW  read entry index.
REQ-013 rd_data  out  LANES*LANE_W  registered read data.
REQ-014 init_busy  out  1  high while the clear sequence runs.

Function
REQ-015 Ports: separate write and read ports; one write and one read may be issued in the same cycle.
REQ-016 Stage 1 (inputs): the block shall register wr_en, wr_addr, wr_data, rd_en and rd_addr on every posedge.
REQ-017 Stage 2 (write): on the edge after stage 1, each lane with a registered enable shall write its lane of the entry.
- Lanes without an enable keep their old value.
REQ-018 Stage 2 (read): the array read uses the stage-1 address; rd_data is registered on the same edge as the write.
- Read latency is 2 cycles from the rd_en sample edge.
REQ-019 Idle read: if the stage-1 rd_en is 0, rd_data shall load all zeros.
REQ-020 Same-address read and write in stage 1: the read is write-first per lane.
- Enabled lanes return the new data; other lanes return the stored data.
REQ-021 Address range: addresses >= DEPTH (non-power-of-2 DEPTH only) shall be ignored for writes and shall read zero.
REQ-022 sehold: while sehold=1, stage-1 registers, array, rd_data, FSM state and clear counter shall hold.
- Requests presented during sehold are lost.
REQ-023 FSM states: IDLE and CLEAR.
- Reset exit goes to CLEAR.
- IDLE goes to CLEAR when clr_req=1.
- CLEAR goes to IDLE after entry DEPTH-1 is written.
REQ-024 CLEAR operation: one entry is zeroed per cycle (all lanes) at counter index 0..DEPTH-1, so CLEAR takes exactly DEPTH cycles.
REQ-025 During CLEAR: init_busy=1, user writes are dropped, user reads return zero, and clr_req is ignored.
REQ-026 init_busy shall fall in the cycle the FSM enters IDLE.
- A request sampled in that cycle is serviced normally.

Reset
REQ-027 rst_l low shall asynchronously set rd_data=0, all stage-1 enables=0, FSM=CLEAR and counter=0.
- Array contents are not reset directly; the CLEAR sequence zeroes them.
REQ-028 init_busy shall be 1 while rst_l is low and throughout the following CLEAR.
REQ-029 Reset asserted during CLEAR shall restart the sequence at entry 0.

Structure
REQ-030 The shared package holds the FSM state encoding (IDLE/CLEAR) and the default LANES, LANE_W and DEPTH constants.
REQ-031 The storage array is a sub-module, bw_r_frf_gen_array: LANES x LANE_W x DEPTH, per-lane write enable, combinational read.
- It contains no reset.

Verification
REQ-032 Scenario: release rst_l, then read addr 5 while init_busy=0.
- init_busy high for 128 cycles; the read returns 0.
REQ-033 Scenario: write addr 3 with wr_en=2'b11 and data 78'h3FFF_0000_1234_5678_9ABC, then read addr 3 one cycle later.
- rd_data equals that value 2 cycles after the read.
REQ-034 Scenario: addr 7 holds all ones; in one cycle write wr_en=2'b01 with data 0 and read addr 7.
- rd_data = {39'h7F_FFFF_FFFF, 39'h0}.
REQ-035 Scenario: hold sehold=1 for 3 cycles mid-stream.
- rd_data and the array are unchanged; the pipeline resumes when sehold drops.
REQ-036 Scenario: pulse clr_req; issue a write during CLEAR; assert rst_l low at counter 60.
- The write is dropped; CLEAR restarts and completes 128 cycles after reset release; all entries read 0.
